// File: rtl/crc_pkg.sv
// Shared types and the single-bit CRC fold for crc_stream_engine.
// Values are carried at 32 bits and masked to crc_w, so one function serves every CRC width.
package crc_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic GEN = 1'b0;
    localparam logic CHK = 1'b1;

    function automatic logic [31:0] next_crc_bit(input logic [31:0] crc, input logic din,
                                                 input logic [31:0] poly, input int crc_w);
        logic        fb;
        logic [31:0] mask;
        fb   = crc[5'(crc_w - 1)] ^ din;
        mask = 32'hFFFF_FFFF >> (32 - crc_w);
        return ((crc << 1) ^ (fb ? poly : 32'h0)) & mask;
    endfunction

endpackage

// File: rtl/crc_stream_engine_step.sv
// crc_step_unit: combinational fold of one whole word into the CRC register, MSB first.
// This module exists only in the CRC_PARALLEL_EN build.
`ifdef CRC_PARALLEL_EN
module crc_step_unit import crc_pkg::*; #(
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 8,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(8'h07)
) (
    input  logic [CRC_W-1:0]  crc_cur,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_next
);

    logic [31:0] acc;

    always_comb begin
        acc = 32'(crc_cur);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            acc = next_crc_bit(acc, data[i], 32'(POLY), CRC_W);
        end
        crc_next = CRC_W'(acc);
    end

endmodule
`endif

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker. Folds framed words MSB first, one bit per clock by default.
// Define CRC_PARALLEL_EN to fold a whole word per accept cycle (1 beat/cycle, same final CRC).
module crc_stream_engine import crc_pkg::*; #(
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 8,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(8'h07),
    parameter logic [CRC_W-1:0] INIT   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [CRC_W-1:0]  crc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_ok,
    output logic              busy
);

    state_t           state;
    logic [CRC_W-1:0] crc;
    logic             started;
    logic             mode_q;

`ifdef CRC_PARALLEL_EN
    logic [CRC_W-1:0] crc_word;
    logic             mode_eff;

    crc_step_unit #(.DATA_W(DATA_W), .CRC_W(CRC_W), .POLY(POLY)) u_step (
        .crc_cur  (crc),
        .data     (in_data),
        .crc_next (crc_word)
    );

    // a single-beat frame takes its mode straight from the port
    assign mode_eff = started ? mode_q : mode;
`else
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] word_q;
    logic [CNT_W-1:0]  cnt;
    logic              last_q;
    logic [CRC_W-1:0]  crc_in_q;
    logic [CRC_W-1:0]  crc_bit;

    assign crc_bit = CRC_W'(next_crc_bit(32'(crc), word_q[cnt], 32'(POLY), CRC_W));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            crc       <= INIT;
            started   <= 1'b0;
            mode_q    <= GEN;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            crc_out   <= '0;
            crc_ok    <= 1'b0;
            busy      <= 1'b0;
`ifndef CRC_PARALLEL_EN
            word_q    <= '0;
            cnt       <= '0;
            last_q    <= 1'b0;
            crc_in_q  <= '0;
`endif
        end else if (clr) begin
            state     <= IDLE;
            crc       <= INIT;
            started   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        started <= 1'b1;
                        busy    <= 1'b1;
                        if (!started) mode_q <= mode;
`ifdef CRC_PARALLEL_EN
                        crc <= crc_word;
                        if (in_last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            crc_out   <= crc_word;
                            crc_ok    <= (mode_eff == CHK) && (crc_word == crc_in);
                        end
`else
                        word_q   <= in_data;
                        last_q   <= in_last;
                        cnt      <= CNT_W'(DATA_W - 1);
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        if (in_last) crc_in_q <= crc_in;
`endif
                    end
                end
`ifndef CRC_PARALLEL_EN
                SHIFT: begin
                    crc <= crc_bit;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        if (last_q) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            crc_out   <= crc_bit;
                            crc_ok    <= (mode_q == CHK) && (crc_bit == crc_in_q);
                        end else begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        crc       <= INIT;
                        started   <= 1'b0;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed plus randomized bench for crc_stream_engine (default parameters: CRC-8, poly 0x07, init 0).
// Expected CRCs come from polynomial long division of the whole frame.
module tb_crc_stream_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] crc_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] crc_out;
    logic       crc_ok;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

`ifdef CRC_PARALLEL_EN
    localparam int LAT   = 1;
    localparam int LOW_N = 0;
`else
    localparam int LAT   = 9;
    localparam int LOW_N = 8;
`endif

    logic [7:0] frame_q[$];
    logic [7:0] res_crc;
    logic       res_ok;
    int         res_lat;

    crc_stream_engine dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .crc_in    (crc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .crc_out   (crc_out),
        .crc_ok    (crc_ok),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // remainder of (message * x^8) divided by x^8 + x^2 + x + 1
    function automatic logic [7:0] model_crc();
        logic [255:0] m;
        int           n;
        m = '0;
        n = frame_q.size() * 8;
        foreach (frame_q[i]) m = (m << 8) | 256'(frame_q[i]);
        m = m << 8;
        for (int i = n + 7; i >= 8; i--) begin
            if (m[i]) m = m ^ (256'(9'h107) << (i - 8));
        end
        return m[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams frame_q; mode/crc_in are deliberately scrambled on non-first / non-last beats.
    task automatic send_frame(input string tag, input logic md, input logic [7:0] ci, input int hold);
        int wait_n;
        int low_bad;
        int stable_bad;
        low_bad    = 0;
        stable_bad = 0;
        for (int i = 0; i < frame_q.size(); i++) begin
            wait_n = 0;
            while (!in_ready && wait_n < 200) begin
                step();
                wait_n++;
            end
            if (i > 0 && wait_n != LOW_N) low_bad++;
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = (i == frame_q.size() - 1);
            mode     = (i == 0) ? md : ~md;
            crc_in   = in_last ? ci : ~ci;
            step();
            in_valid = 1'b0;
            in_last  = 1'b0;
            mode     = ~md;
        end
        res_lat = 1;
        while (!out_valid && res_lat < 200) begin
            step();
            res_lat++;
        end
        res_crc = crc_out;
        res_ok  = crc_ok;
        for (int k = 0; k < hold; k++) begin
            step();
            if (out_valid !== 1'b1 || crc_out !== res_crc || in_ready !== 1'b0) stable_bad++;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_ready_low_per_beat"}, low_bad, 0);
        check({tag, "_hold_stable"}, stable_bad, 0);
        check({tag, "_release_idle"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        logic [7:0] exp_crc;
        logic [7:0] ci;
        logic       md;
        int         len;
        int         seen;

        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_crc_out", crc_out, 0);
        check("rst_crc_ok", crc_ok, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        // single word 0x80
        frame_q = {8'h80};
        send_frame("gen80", 1'b0, 8'h00, 0);
        check("gen80_crc", res_crc, 8'h89);
        check("gen80_model", res_crc, model_crc());
        check("gen80_ok", res_ok, 0);
        check("gen80_latency", res_lat, LAT);

        // "123456789"
        frame_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        send_frame("gen_check", 1'b0, 8'h00, 0);
        check("gen_check_crc", res_crc, 8'hF4);
        check("gen_check_model", res_crc, model_crc());
        check("gen_check_ok", res_ok, 0);
        check("gen_check_latency", res_lat, LAT);

        send_frame("chk_good", 1'b1, 8'hF4, 0);
        check("chk_good_ok", res_ok, 1);
        check("chk_good_crc", res_crc, 8'hF4);
        send_frame("chk_bad", 1'b1, 8'hF5, 0);
        check("chk_bad_ok", res_ok, 0);
        check("chk_bad_crc", res_crc, 8'hF4);

        // backpressure in DONE, then crc must be reloaded
        frame_q = {8'h80};
        send_frame("bp", 1'b0, 8'h00, 20);
        check("bp_crc", res_crc, 8'h89);
        frame_q = {8'h01};
        send_frame("after_bp", 1'b0, 8'h00, 0);
        check("after_bp_crc", res_crc, 8'h07);

        // abort on the 2nd beat of a 3-word frame, clr coinciding with the handshake
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_last  = 1'b0;
        step();
        in_valid = 1'b0;
        check("abort_busy_first_beat", busy, 1);
        seen = 0;
        while (!in_ready && seen < 200) begin
            step();
            seen++;
        end
        check("abort_wait_ready", seen, LOW_N);
        in_valid = 1'b1;
        in_data  = 8'h22;
        clr      = 1'b1;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        check("abort_idle", {in_ready, out_valid, busy}, 3'b100);
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (out_valid) seen++;
        end
        check("abort_no_out_valid", seen, 0);
        frame_q = {8'h80};
        send_frame("after_abort", 1'b0, 8'h00, 0);
        check("after_abort_crc", res_crc, 8'h89);

        // async reset mid-SHIFT, with a completed result still in crc_out
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_last  = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_outputs", {in_ready, out_valid, crc_ok, busy}, 4'b1000);
        check("midrst_crc_out", crc_out, 0);
        step();
        rst = 1'b1;
        step();
        frame_q = {8'h80};
        send_frame("after_rst", 1'b0, 8'h00, 0);
        check("after_rst_crc", res_crc, 8'h89);

        // randomized frames against the division model
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 6);
            frame_q.delete();
            for (int k = 0; k < len; k++) frame_q.push_back(8'($urandom));
            exp_crc = model_crc();
            md = 1'($urandom);
            ci = ($urandom_range(0, 1) == 1) ? exp_crc : 8'($urandom);
            send_frame("rand", md, ci, $urandom_range(0, 3));
            check("rand_crc", res_crc, exp_crc);
            check("rand_ok", res_ok, (md && ci == exp_crc) ? 1 : 0);
            check("rand_latency", res_lat, LAT);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
Parametrised streaming CRC generator/checker. It is the successor to the fixed 8/16/20-bit byte-serial CRC encoder/decoder.
- Accepts a framed word stream over a valid/ready handshake.
- Folds each word into a CRC register, MSB first, one bit per clock.
- On the last beat it presents either the generated CRC (generate mode) or a pass/fail verdict against a supplied CRC (check mode).
- Sits between the input byte source and the MLP data path, guarding weight/sample transfers.

Parameters:
DATA_W, 8, input word width in bits (1..32)
CRC_W, 8, CRC register width in bits (4..32)
POLY, 8'h07, generator polynomial without the implicit x^CRC_W term
INIT, 0, CRC register value at frame start

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
clr  in  1  synchronous abort; returns to IDLE, discards frame
mode  in  1  0 = generate, 1 = check; sampled on the first beat of a frame
in_data  in  DATA_W  data word, MSB processed first
in_valid  in  1  word valid
in_last  in  1  final word of frame
in_ready  out  1  engine can accept a word
crc_in  in  CRC_W  expected CRC; sampled with the last beat in check mode
out_valid  out  1  result available
out_ready  in  1  result consumed
crc_out  out  CRC_W  final CRC register
crc_ok  out  1  check mode: crc_out == crc_in; generate mode: 0
busy  out  1  frame in progress (state != IDLE or a frame has started)

Behaviour:
- Reset (rst low, async): state IDLE; crc = INIT; bit counter 0; in_ready = 1; out_valid = 0; crc_out = 0; crc_ok = 0; busy = 0.
- States: IDLE, SHIFT, DONE.
  - IDLE: in_ready = 1. A handshake (in_valid & in_ready) latches the word, in_last, and mode (first beat only), plus crc_in if last. Then go to SHIFT with counter = DATA_W-1.
  - SHIFT: in_ready = 0. Each cycle: fb = crc[CRC_W-1] ^ word[counter]; crc = (crc<<1) ^ (fb ? POLY : 0); counter decrements. After bit 0: if the latched last is set, go to DONE, else go to IDLE.
  - DONE: out_valid = 1; crc_out and crc_ok stable. On out_ready, go to IDLE, reload crc = INIT and clear the frame-started flag.
- Throughput: DATA_W+1 cycles per beat (1 accept + DATA_W shift). out_valid asserts the cycle after the final shift.
- A frame of one word with in_last = 1 is legal.
- in_valid while in_ready = 0 is ignored; the source must hold.
- crc is not reloaded between non-last beats.
- mode is frozen from first beat to DONE; mid-frame changes have no effect.
- clr has priority over all events, including out_ready and handshakes in the same cycle. Effect: state IDLE, crc = INIT, out_valid = 0.
- Reset mid-frame: identical to the reset state; the partial frame is lost.
- crc_ok compare width is CRC_W; all arithmetic is modulo 2 at width CRC_W.

Optional Feature:
CRC_PARALLEL_EN
- Defined: the SHIFT loop is unrolled combinationally. A whole word is folded in the accept cycle and SHIFT is skipped: IDLE goes directly to DONE (last) or stays in IDLE. in_ready stays 1 across non-last beats, giving 1 beat/cycle. out_valid asserts 1 cycle after the last handshake.
- Undefined: bit-serial behaviour as above.
- Final CRC values are identical in both builds.

Decomposition:
- Shared package `crc_pkg`:
  - state enum {IDLE, SHIFT, DONE}
  - mode constants GEN = 0, CHK = 1
  - a function next_crc_bit(crc, bit, poly), reused by the unrolled path
- Natural sub-module: `crc_step_unit`, the combinational one-word fold. It is instantiated only under CRC_PARALLEL_EN.

Test Plan:
- Defaults, generate, single word 0x80, last = 1: out_valid after 9 cycles; crc_out = 0x89, crc_ok = 0.
- Generate, words 0x31..0x39 ("123456789"), last on 0x39: crc_out = 0xF4; in_ready low 8 of every 9 cycles.
- Check, same stream, crc_in = 0xF4 → crc_ok = 1. Repeat with crc_in = 0xF5 → crc_ok = 0, crc_out = 0xF4.
- Backpressure: hold out_ready = 0 for 20 cycles in DONE. out_valid and crc_out stay stable; in_ready = 0. Then out_ready = 1 → IDLE, and the next frame 0x01 yields 0x07 (crc reloaded).
- Abort: clr during the 2nd beat of a 3-word frame → in_ready = 1 next cycle, out_valid never asserts. A following frame 0x80 yields 0x89. Also assert rst low mid-SHIFT → all outputs at reset values.
- CRC_PARALLEL_EN build: "123456789" streamed back-to-back, one word per cycle → crc_out = 0xF4, out_valid 1 cycle after the last handshake.
